// File: rtl/mdiv_pkg.sv
// mdiv_pkg: shared definitions for the iterative multiply/divide unit.
//   mdiv_op_t    - operation codes carried on the OP bus with START
//   mdiv_state_t - sequencer states
//   MDIV_W       - default operand width
package mdiv_pkg;

  localparam int MDIV_W = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } mdiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdiv_state_t;

endpackage

// File: rtl/mdiv_unit.sv
// mdiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, plus MTHI/MTLO.
//   i_clk    core clock
//   i_rst    asynchronous active-high reset
//   i_start  one-cycle operation strobe
//   i_op     operation code (mdiv_op_t), valid with i_start
//   i_a      rs operand (dividend / multiplicand / MTHI/MTLO source)
//   i_b      rt operand (divisor / multiplier)
//   o_busy   result pending; HI/LO not yet valid
//   o_hi     architected HI
//   o_lo     architected LO
// One iteration per cycle for W cycles (RUN), then one sign-fix cycle (FIX)
// that writes HI/LO. Any mul/div or MTHI/MTLO strobe aborts an op in flight.
module mdiv_unit
  import mdiv_pkg::*;
#(
  parameter int W = MDIV_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  localparam int CW = $clog2(W);

  mdiv_state_t r_state, w_state_nxt;
  logic          r_busy;
  logic [CW-1:0] r_cnt;
  // Working pair: multiply uses {r_wh,r_wl} as the product accumulator,
  // divide uses r_wh as remainder and r_wl as quotient.
  logic [W-1:0]  r_wh, r_wl, r_b;
  logic          r_is_div, r_neg_q, r_neg_r;
  logic [W-1:0]  r_hi, r_lo;

  logic          w_is_md, w_is_mt, w_signed, w_a_neg, w_b_neg;
  logic [W-1:0]  w_a_abs, w_b_abs;
  logic [W:0]    w_mul_sum;
  logic [W:0]    w_rsh;
  logic [W+1:0]  w_diff;
  logic          w_fits;
  logic [2*W-1:0] w_prod, w_prod_s;
  logic [W-1:0]  w_q_s, w_r_s;

  // Operation decode; 110/111 decode to neither class and are ignored.
  assign w_is_md  = i_start && (i_op == OP_MULT || i_op == OP_MULTU ||
                                i_op == OP_DIV  || i_op == OP_DIVU);
  assign w_is_mt  = i_start && (i_op == OP_MTHI || i_op == OP_MTLO);
  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign w_a_neg  = w_signed & i_a[W-1];
  assign w_b_neg  = w_signed & i_b[W-1];
  assign w_a_abs  = w_a_neg ? -i_a : i_a;
  assign w_b_abs  = w_b_neg ? -i_b : i_b;

  // Multiply step: conditional add with carry out, carry shifts into the top.
  assign w_mul_sum = {1'b0, r_wh} + (r_wl[0] ? {1'b0, r_b} : '0);

  // Divide step: the shifted remainder needs W+1 bits; the stored remainder
  // is always below the divisor (or equals shifted-in dividend bits for a
  // zero divisor), so W bits of storage are enough.
  assign w_rsh  = {r_wh, r_wl[W-1]};
  assign w_diff = {1'b0, w_rsh} - {2'b00, r_b};
  assign w_fits = ~w_diff[W+1];

  // Sign fix-up applied in FIX.
  assign w_prod   = {r_wh, r_wl};
  assign w_prod_s = r_neg_q ? -w_prod : w_prod;
  assign w_q_s    = r_neg_q ? -r_wl : r_wl;
  assign w_r_s    = r_neg_r ? -r_wh : r_wh;

  // Next state: a new mul/div always wins (restart), MTHI/MTLO aborts.
  always_comb begin
    w_state_nxt = r_state;
    if (w_is_md) begin
      w_state_nxt = RUN;
    end else if (w_is_mt) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        RUN:     w_state_nxt = (r_cnt == CW'(W-1)) ? FIX : RUN;
        FIX:     w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt    <= '0;
      r_wh     <= '0;
      r_wl     <= '0;
      r_b      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_is_md) begin
        r_cnt    <= '0;
        r_wh     <= '0;
        r_wl     <= w_a_abs;
        r_b      <= w_b_abs;
        r_is_div <= i_op[1];
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
      end else if (r_state == RUN) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_is_div) begin
          r_wh <= w_fits ? w_diff[W-1:0] : w_rsh[W-1:0];
          r_wl <= {r_wl[W-2:0], w_fits};
        end else begin
          r_wh <= w_mul_sum[W:1];
          r_wl <= {w_mul_sum[0], r_wl[W-1:1]};
        end
      end

      // HI/LO: MTHI/MTLO at the strobe, results only on an uninterrupted FIX.
      if (w_is_mt) begin
        if (i_op == OP_MTHI) r_hi <= i_a;
        else                 r_lo <= i_a;
      end else if (r_state == FIX && !w_is_md) begin
        if (r_is_div) begin
          r_hi <= w_r_s;
          r_lo <= w_q_s;
        end else begin
          r_hi <= w_prod_s[2*W-1:W];
          r_lo <= w_prod_s[W-1:0];
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: doc/mdiv_unit.md
Name: mdiv_unit

Overview:
- Iterative multiply/divide unit in the M stage. It is the producer side of the pipeline's multiply/divide stall interface.
- It executes MULT/MULTU/DIV/DIVU over a fixed number of cycles and owns the architected HI/LO registers. It also executes MTHI/MTLO.
- It raises BUSY while a result is pending. The hazard logic combines BUSY with an MFHI/MFLO in M to stall the pipeline.

Parameters:
- W, 32, operand width. HI/LO are W bits each; the iteration count equals W.

Ports:
- CLK  in  1  core clock
- RESET  in  1  asynchronous, active-high reset
- START  in  1  one-cycle operation strobe from M stage
- OP  in  3  operation code, valid with START
- A  in  W  rs operand (dividend / multiplicand / MTHI/MTLO source)
- B  in  W  rt operand (divisor / multiplier)
- BUSY  out  1  result pending; HI/LO not yet valid
- HI  out  W  architected HI
- LO  out  W  architected LO

Behaviour:
- Reset (async, RESET=1): state=IDLE, BUSY=0, HI=0, LO=0, counter=0, working registers=0.
- OP encoding: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO. 110/111 are ignored as no-op; the current state is kept.
- FSM states: IDLE, RUN, FIX.
  - IDLE + START(mul/div) -> RUN.
  - RUN: one iteration per cycle, 5-bit counter 0..W-1. Counter==W-1 -> FIX.
  - FIX -> IDLE.
- BUSY is registered. It is 1 in RUN and FIX, i.e. exactly W+1 cycles starting the cycle after START.
- HI/LO are loaded on the FIX->IDLE edge, so they are valid in the first cycle BUSY=0. Result latency from START is W+2 clock edges.
- Signed ops (MULT/DIV): on START, latch |A|, |B| and the sign flags. Unsigned ops use the raw operands. Signs are applied in FIX.
- Multiply: 2W-bit accumulator {P_hi,P_lo}, initialised {0,A}. Each RUN cycle:
  - if P_lo[0], add B to P_hi with a (W+1)-bit carry;
  - then shift the whole accumulator right by 1, bringing the carry in.
  - FIX: negate the 2W-bit product if sign(A)^sign(B). HI=upper W bits, LO=lower W bits.
- Divide: restoring division. Remainder register R (W+1 bits) = 0, quotient Q = A. Each RUN cycle:
  - shift {R,Q} left by 1;
  - trial R-B; if non-negative, R=R-B and Q[0]=1.
  - FIX: LO=Q, negated if sign(A)^sign(B). HI=R, negated if sign(A).
- Divide by zero is not special-cased. The algorithm yields Q=all-ones and R=|A| before the sign fix.
- MTHI/MTLO: written at the START edge; BUSY unaffected. If issued while BUSY=1, the in-flight op is aborted: state->IDLE, BUSY=0 next cycle, and the other register is left unchanged.
- START with mul/div while BUSY=1 aborts the in-flight op and restarts with the new operands. The counter resets to 0 and HI/LO keep their old values until the new FIX.
- START coinciding with the FIX cycle: the new op takes priority and the old result is discarded. The new op goes to RUN, and BUSY stays 1 continuously.
- RESET mid-operation: immediate return to reset values; no partial HI/LO update.
- HI/LO change only on FIX completion, MTHI/MTLO, or RESET.

Decomposition:
- Shared package mdiv_pkg:
  - enum mdiv_op_t with the encodings above;
  - enum mdiv_state_t {IDLE,RUN,FIX};
  - localparam MDIV_W=32.
- Single module. The datapath (add/shift, subtract/restore, negate) is small; no sub-module.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> BUSY high exactly 33 cycles starting the cycle after START; then HI=0xFFFFFFFE, LO=0x00000001.
- MULT A=0xFFFFFFFE (-2), B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFA. DIV A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=7, B=0 -> LO=0xFFFFFFFF, HI=7. DIV A=-7, B=0 -> LO=0x00000001, HI=0xFFFFFFF9.
- MULTU 3*5 started, then MTHI A=0x1234 on cycle 10 -> BUSY=0 the next cycle; HI=0x1234, LO keeps its pre-op value; no later result write.
- MULTU 2*2 then MULTU 6*7 started on the FIX cycle of the first -> BUSY stays 1 with no gap; final HI=0, LO=42; the result 4 never appears on LO.
- RESET asserted asynchronously mid-RUN (between clock edges) -> BUSY, HI and LO go to 0 immediately; the next START after RESET deasserts runs normally.
